output_accum_writeback: RTL and testbench

//  Successor output write-back stage for the conv engine: per-lane fixed-point accumulate of conv partial sums into a

---
 rtl/output_accum_writeback.sv | 177 +++++++++++++++++
 tb/tb_output_accum_writeback.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/output_accum_writeback.sv
// Per-lane accumulate/write-back stage: bias seeding, RAW bypass, ReLU commit, post-reset clear sweep, sticky overflow.
// Define OUTPUT_ACC_SAT_EN to clamp on overflow; the default build wraps modulo 2^DATA_WIDTH.
module output_accum_writeback #(
   parameter int DATA_WIDTH = 32,
   parameter int FRAC_WIDTH = 16,
   parameter int LANES      = 4,
   parameter int DEPTH      = 1152,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                        i_clock,
   input  logic                        i_reset,
   input  logic                        i_enable,
   input  logic                        i_valid,
   input  logic                        i_first,
   input  logic                        i_last,
   input  logic                        i_relu,
   input  logic [ADDR_WIDTH-1:0]       i_addr,
   input  logic [LANES*DATA_WIDTH-1:0] i_conv,
   input  logic [LANES*DATA_WIDTH-1:0] i_bias,
   input  logic                        i_clear,
   input  logic                        i_rd_en,
   input  logic [ADDR_WIDTH-1:0]       i_rd_addr,
   output logic [LANES*DATA_WIDTH-1:0] o_rd_data,
   output logic                        o_rd_valid,
   output logic                        o_ready,
   output logic [LANES-1:0]            o_overflow
);
   localparam int DW = DATA_WIDTH;
   localparam int LW = LANES * DATA_WIDTH;
   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   // Fractional bits only describe the number format; the adder works on raw words.
   if (FRAC_WIDTH >= DATA_WIDTH) begin : g_bad_frac
      $error("FRAC_WIDTH must be smaller than DATA_WIDTH");
   end

   function automatic logic [DW:0] acc_lane(input logic signed [DW-1:0] a,
                                            input logic signed [DW-1:0] b);
      logic signed [DW-1:0] s;
      logic                 ovf;
      s   = a + b;
      ovf = (a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1]);
`ifdef OUTPUT_ACC_SAT_EN
      if (ovf) s = a[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
      return {ovf, s};
   endfunction

   function automatic logic [LW-1:0] relu_act(input logic [LW-1:0] w, input logic en);
      logic [LW-1:0] r;
      r = w;
      for (int k = 0; k < LANES; k++)
         if (en && w[k*DW+DW-1]) r[k*DW +: DW] = '0;
      return r;
   endfunction

   logic [LW-1:0] pbank [DEPTH];
   logic [LW-1:0] obank [DEPTH];

   logic [0:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  run, flush, wr_en;

   logic                  vld_p1_q, first_p1_q, last_p1_q, relu_p1_q;
   logic [ADDR_WIDTH-1:0] addr_p1_q;
   logic [LW-1:0]         conv_p1_q, bias_p1_q, prd_p1_q;
   logic                  vld_p2_q, last_p2_q, relu_p2_q;
   logic [ADDR_WIDTH-1:0] addr_p2_q;
   logic [LW-1:0]         sum_p2_q, sum_p2_d, opnd_p1;
   logic                  w_vld_q;
   logic [ADDR_WIDTH-1:0] w_addr_q;
   logic [LW-1:0]         w_data_q;
   logic [LANES-1:0]      ovf_p1, ovf_q;

   assign run   = (state_q == ST_RUN);
   assign flush = run & i_clear;
   assign wr_en = run & i_enable & vld_p2_q & ~i_clear;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!run) begin
         cnt_d = cnt_q + ADDR_WIDTH'(1);
         if (cnt_q == LAST_ADDR) begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      end else if (i_clear) begin
         state_d = ST_CLEAR;
         cnt_d   = '0;
      end
   end

   // S1: operand select (seed / youngest in-flight write / bank) and per-lane add
   always_comb begin
      sum_p2_d = '0;
      ovf_p1   = '0;
      if (first_p1_q)                                opnd_p1 = bias_p1_q;
      else if (vld_p2_q && (addr_p2_q == addr_p1_q)) opnd_p1 = sum_p2_q;
      else if (w_vld_q && (w_addr_q == addr_p1_q))   opnd_p1 = w_data_q;
      else                                           opnd_p1 = prd_p1_q;
      for (int k = 0; k < LANES; k++)
         {ovf_p1[k], sum_p2_d[k*DW +: DW]} = acc_lane(opnd_p1[k*DW +: DW], conv_p1_q[k*DW +: DW]);
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q  <= ST_CLEAR;
         cnt_q    <= '0;
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         w_vld_q  <= 1'b0;
         ovf_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (!run || i_clear) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            w_vld_q  <= 1'b0;
         end else if (i_enable) begin
            vld_p1_q <= i_valid;
            vld_p2_q <= vld_p1_q;
            if (vld_p2_q) w_vld_q <= 1'b1;
         end
         if (flush)                             ovf_q <= '0;
         else if (run && i_enable && vld_p1_q)  ovf_q <= ovf_q | ovf_p1;
      end
   end

   // P0 -> P1 -> P2 data registers and the last-write (W) register
   always_ff @(posedge i_clock) begin
      if (i_enable) begin
         addr_p1_q  <= i_addr;
         first_p1_q <= i_first;
         last_p1_q  <= i_last;
         relu_p1_q  <= i_relu;
         conv_p1_q  <= i_conv;
         bias_p1_q  <= i_bias;
         addr_p2_q  <= addr_p1_q;
         last_p2_q  <= last_p1_q;
         relu_p2_q  <= relu_p1_q;
         sum_p2_q   <= sum_p2_d;
      end
      if (wr_en) begin
         w_addr_q <= addr_p2_q;
         w_data_q <= sum_p2_q;
      end
   end

   // Banks are read-first: the partial read here sees the value before this edge's write.
   always_ff @(posedge i_clock) begin
      if (i_enable) prd_p1_q <= pbank[i_addr];
      if (!run) begin
         pbank[cnt_q] <= '0;
         obank[cnt_q] <= '0;
      end else if (wr_en) begin
         pbank[addr_p2_q] <= sum_p2_q;
         if (last_p2_q) obank[addr_p2_q] <= relu_act(sum_p2_q, relu_p2_q);
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         o_rd_data  <= '0;
         o_rd_valid <= 1'b0;
      end else begin
         o_rd_valid <= i_rd_en;
         if (i_rd_en) o_rd_data <= obank[i_rd_addr];
      end
   end

   assign o_ready    = run;
   assign o_overflow = ovf_q;
endmodule

// File: tb/tb_output_accum_writeback.sv
// Scoreboard bench for output_accum_writeback: a reference model fills expected read data, the read monitor checks it.
module tb_output_accum_writeback;
   localparam int DW = 32, LANES = 4, DEPTH = 1152, AW = $clog2(DEPTH), LW = DW * LANES;

   logic clk = 1'b0, rst_n = 1'b1, en = 1'b1, vld = 1'b0, first = 1'b0, last = 1'b0, relu = 1'b0;
   logic clr = 1'b0, rd_en = 1'b0;
   logic [AW-1:0] addr = '0, rd_addr = '0;
   logic [LW-1:0] conv = '0, bias = '0;
   logic [LW-1:0] rd_data;
   logic rd_valid, ready;
   logic [LANES-1:0] ovf;

   int checks = 0, failures = 0, n;
   logic [LW-1:0] pm [int];
   logic [LW-1:0] om [int];
   logic [LW-1:0] exp_q [$];
   string tag_q [$];
   string mon_tag;
   logic [LW-1:0] mon_exp;

   always #5 clk = ~clk;

   output_accum_writeback dut (
      .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_valid(vld), .i_first(first), .i_last(last),
      .i_relu(relu), .i_addr(addr), .i_conv(conv), .i_bias(bias), .i_clear(clr), .i_rd_en(rd_en),
      .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_ready(ready), .o_overflow(ovf)
   );

   task automatic check(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [LW-1:0] rep(input logic [DW-1:0] x);
      return {LANES{x}};
   endfunction

   function automatic logic [LW-1:0] om_get(input int a);
      return om.exists(a) ? om[a] : '0;
   endfunction

   // Reference: samples applied in program order with exact-width range check for overflow.
   task automatic model(input logic f, input logic l, input logic r, input int a,
                        input logic [LW-1:0] c, input logic [LW-1:0] b);
      logic [LW-1:0] base, s, act;
      base = f ? b : (pm.exists(a) ? pm[a] : '0);
      for (int k = 0; k < LANES; k++) begin
         longint w;
         w = longint'($signed(base[k*DW +: DW])) + longint'($signed(c[k*DW +: DW]));
`ifdef OUTPUT_ACC_SAT_EN
         if (w > 64'sd2147483647) w = 64'sd2147483647;
         if (w < -64'sd2147483648) w = -64'sd2147483648;
`endif
         s[k*DW +: DW]   = w[DW-1:0];
         act[k*DW +: DW] = (r && w[DW-1]) ? '0 : w[DW-1:0];
      end
      pm[a] = s;
      if (l) om[a] = act;
   endtask

   task automatic send(input logic f, input logic l, input logic r, input int a,
                       input logic [LW-1:0] c, input logic [LW-1:0] b);
      @(negedge clk);
      vld = 1'b1; first = f; last = l; relu = r; addr = AW'(a); conv = c; bias = b; rd_en = 1'b0;
      if (en && ready) model(f, l, r, a, c, b);
   endtask

   task automatic rd(input int a, input logic [LW-1:0] e, input string t);
      @(negedge clk);
      vld = 1'b0; rd_en = 1'b1; rd_addr = AW'(a);
      exp_q.push_back(e);
      tag_q.push_back(t);
   endtask

   task automatic idle(input int cycles);
      repeat (cycles) begin
         @(negedge clk);
         vld = 1'b0; rd_en = 1'b0;
      end
   endtask

   task automatic wait_ready(input string t);
      n = 0;
      while (n < DEPTH + 20 && !ready) begin
         @(posedge clk); #1; n++;
      end
      check(t, n, DEPTH);
   endtask

   always @(negedge clk) begin
      if (rst_n && rd_valid) begin
         if (exp_q.size() == 0) check("rd_unexpected", 1'b1, 1'b0);
         else begin
            mon_tag = tag_q.pop_front();
            mon_exp = exp_q.pop_front();
            check(mon_tag, rd_data, mon_exp);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", ready, 1'b0);
      check("rst_rd_valid", rd_valid, 1'b0);
      check("rst_rd_data", rd_data, '0);
      check("rst_overflow", ovf, '0);
      @(negedge clk) rst_n = 1'b1;
      wait_ready("ready_latency");
      rd(0, '0, "sweep_a0"); rd(DEPTH - 1, '0, "sweep_top"); rd(5, '0, "sweep_a5");

      // single-pass write-back, read on the write edge returns old, next cycle new
      send(1'b1, 1'b1, 1'b0, 5, rep(32'h0002_0000), rep(32'h0001_0000));
      idle(1);
      rd(5, '0, "wb_same_edge_old");
      rd(5, rep(32'h0003_0000), "wb_t3");

      send(1'b1, 1'b0, 1'b0, 7, rep(32'd1), rep(32'd10));
      send(1'b0, 1'b0, 1'b0, 7, rep(32'd2), '0);
      send(1'b0, 1'b1, 1'b0, 7, rep(32'd3), '0);
      idle(3);
      rd(7, rep(32'd16), "bypass_d1");

      send(1'b1, 1'b0, 1'b0, 9, rep(32'd1), rep(32'd100));
      send(1'b1, 1'b1, 1'b0, 11, rep(32'd50), '0);
      send(1'b0, 1'b1, 1'b0, 9, rep(32'd2), '0);
      send(1'b1, 1'b0, 1'b0, 13, rep(32'd4), rep(32'd20));
      send(1'b1, 1'b0, 1'b0, 14, rep(32'd1), '0);
      send(1'b1, 1'b0, 1'b0, 15, rep(32'd1), '0);
      send(1'b0, 1'b1, 1'b0, 13, rep(32'd6), '0);
      idle(3);
      rd(9, rep(32'd103), "bypass_d2");
      rd(11, rep(32'd50), "bypass_other");
      rd(13, rep(32'd30), "bank_d3");

      send(1'b1, 1'b1, 1'b1, 40, '0, rep(32'hFFFF_0000));
      send(1'b1, 1'b1, 1'b0, 41, '0, rep(32'hFFFF_0000));
      idle(3);
      rd(40, '0, "relu_neg");
      rd(41, rep(32'hFFFF_0000), "norelu_neg");
      send(1'b0, 1'b1, 1'b0, 40, rep(32'h0002_0000), '0);
      idle(3);
      rd(40, rep(32'h0001_0000), "partial_unact");

      // lane 1 positive overflow, lane 3 negative overflow
      send(1'b1, 1'b1, 1'b0, 50, {32'hFFFF_FFFF, 32'd0, 32'h0000_0020, 32'd0},
                                 {32'h8000_0000, 32'd0, 32'h7FFF_FFF0, 32'd0});
      idle(3);
      check("ovf_flags", ovf, 4'b1010);
`ifdef OUTPUT_ACC_SAT_EN
      rd(50, {32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 32'd0}, "ovf_data");
`else
      rd(50, {32'h7FFF_FFFF, 32'd0, 32'h8000_0010, 32'd0}, "ovf_data");
`endif
      rd(50, om_get(50), "ovf_model");

      // burst, then freeze 5 cycles with garbage on the inputs
      send(1'b1, 1'b0, 1'b0, 60, rep(32'd100), rep(32'd1000));
      send(1'b1, 1'b1, 1'b0, 61, rep(32'd5), rep(32'd6));
      send(1'b0, 1'b1, 1'b0, 60, rep(32'd7), '0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         en = 1'b0; vld = 1'b1; first = 1'b1; last = 1'b1; addr = AW'(60);
         conv = rep(32'h5555); bias = rep(32'd1);
         rd_en = 1'b1; rd_addr = AW'((i % 2 == 1) ? 60 : 61);
         exp_q.push_back('0);
         tag_q.push_back("frozen_no_write");
      end
      @(negedge clk);
      en = 1'b1; vld = 1'b0; rd_en = 1'b0;
      idle(3);
      rd(60, rep(32'd1107), "stall_result60");
      rd(61, rep(32'd11), "stall_result61");
      idle(2);
      check("ovf_sticky", ovf, 4'b1010);

      // overflowing sample in flight when the clear arrives is dropped
      send(1'b1, 1'b1, 1'b0, 70, {96'd0, 32'h0000_0020}, {96'd0, 32'h7FFF_FFF0});
      @(negedge clk);
      vld = 1'b0; clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clear_ready_low", ready, 1'b0);
      check("clear_ovf", ovf, '0);
      wait_ready("clear_latency");
      pm.delete(); om.delete();
      check("clear_ovf_after", ovf, '0);
      rd(5, '0, "clear_a5"); rd(7, '0, "clear_a7"); rd(50, '0, "clear_a50");
      rd(60, '0, "clear_a60"); rd(70, '0, "clear_a70");
      send(1'b1, 1'b1, 1'b0, 5, rep(32'd3), rep(32'd4));
      idle(3);
      rd(5, rep(32'd7), "post_clear_run");
      idle(4);
      check("sb_drain", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
